// File: rtl/circuit_delay_pipe_if.sv
// Operand/result bundle for the two-gate delay-path model.
interface circuit_delay_pipe_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr_cnt;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] c_ideal;
  logic             c_valid;
  logic [WIDTH-1:0] mismatch;
  logic [CNT_W-1:0] mism_cnt;
  logic             cnt_sat;

  modport master (
    output a, b, clr_cnt,
    input  c, c_ideal, c_valid, mismatch, mism_cnt, cnt_sat
  );

  modport slave (
    input  a, b, clr_cnt,
    output c, c_ideal, c_valid, mismatch, mism_cnt, cnt_sat
  );
endinterface

// File: rtl/circuit_delay_pipe.sv
// Clocked model of w = a & b, c = w | b with per-gate cycle delays; the real result
// is compared against an ideally aligned copy and hazard cycles are counted.
module circuit_delay_pipe #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned D1    = 5,
  parameter int unsigned D2    = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  circuit_delay_pipe_if.slave bus
);
  localparam int unsigned TOTAL  = D1 + D2;
  localparam int unsigned FILL_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]  w_pipe     [D1];
  logic [WIDTH-1:0]  c_pipe     [D2];
  logic [WIDTH-1:0]  ideal_pipe [TOTAL];
  logic [FILL_W-1:0] fill_cnt;
  logic [CNT_W-1:0]  mism_cnt;
  logic              cnt_sat;
  logic              c_valid;
  logic [WIDTH-1:0]  or_in;
  logic [WIDTH-1:0]  mismatch;

  // Second gate sees the delayed AND result but the current b: the hazard path.
  assign or_in    = w_pipe[D1-1] | bus.b;
  assign c_valid  = (fill_cnt == FILL_W'(TOTAL));
  assign mismatch = c_valid ? (c_pipe[D2-1] ^ ideal_pipe[TOTAL-1]) : '0;

  assign bus.c        = c_pipe[D2-1];
  assign bus.c_ideal  = ideal_pipe[TOTAL-1];
  assign bus.c_valid  = c_valid;
  assign bus.mismatch = mismatch;
  assign bus.mism_cnt = mism_cnt;
  assign bus.cnt_sat  = cnt_sat;

  // First-gate (AND) delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(D1); i++) w_pipe[i] <= '0;
    end else begin
      w_pipe[0] <= bus.a & bus.b;
      for (int i = 1; i < int'(D1); i++) w_pipe[i] <= w_pipe[i-1];
    end
  end

  // Second-gate (OR) delay line producing the real result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(D2); i++) c_pipe[i] <= '0;
    end else begin
      c_pipe[0] <= or_in;
      for (int i = 1; i < int'(D2); i++) c_pipe[i] <= c_pipe[i-1];
    end
  end

  // Ideal result delayed by the full path latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(TOTAL); i++) ideal_pipe[i] <= '0;
    end else begin
      ideal_pipe[0] <= (bus.a & bus.b) | bus.b;
      for (int i = 1; i < int'(TOTAL); i++) ideal_pipe[i] <= ideal_pipe[i-1];
    end
  end

  // Fill counter: saturates once every stage holds post-reset data.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= '0;
    end else if (!c_valid) begin
      fill_cnt <= fill_cnt + FILL_W'(1);
    end
  end

  // Hazard counter: clear beats increment; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      mism_cnt <= '0;
      cnt_sat  <= 1'b0;
    end else if (bus.clr_cnt) begin
      mism_cnt <= '0;
      cnt_sat  <= 1'b0;
    end else if (c_valid && (|mismatch) && !cnt_sat) begin
      mism_cnt <= mism_cnt + CNT_W'(1);
      if (mism_cnt == CNT_MAX - CNT_W'(1)) cnt_sat <= 1'b1;
    end
  end
endmodule

// File: tb/tb_circuit_delay_pipe.sv
// Scoreboard bench for circuit_delay_pipe: an 8-bit and a 3-bit counter instance
// share the same stimulus; expectations come from an input-history model.
module tb_circuit_delay_pipe;
  logic clk = 1'b0;
  logic rst;
  logic a, b, clr_cnt;

  always #5 clk = ~clk;

  circuit_delay_pipe_if #(.WIDTH(1), .CNT_W(8)) if8 ();
  circuit_delay_pipe_if #(.WIDTH(1), .CNT_W(3)) if3 ();

  assign if8.a = a;  assign if8.b = b;  assign if8.clr_cnt = clr_cnt;
  assign if3.a = a;  assign if3.b = b;  assign if3.clr_cnt = clr_cnt;

  circuit_delay_pipe #(.WIDTH(1), .D1(5), .D2(1), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .bus(if8.slave));
  circuit_delay_pipe #(.WIDTH(1), .D1(5), .D2(1), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave));

  typedef struct {
    logic       c;
    logic       ci;
    logic       v;
    logic       m;
    logic [7:0] n8;
    logic       s8;
    logic [2:0] n3;
    logic       s3;
  } exp_t;

  exp_t sb[$];
  bit   ab_log[$];
  bit   b_log[$];
  int   k        = 0;
  int   rst_edge = -1;
  int   cnt8 = 0, cnt3 = 0;
  bit   sat8 = 0, sat3 = 0, prev_m = 0;
  int   n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s edge=%0d: got %0h expected %0h", tag, k - 1, obs, exp);
  endtask

  // Expected outputs after the coming edge, derived from the logged inputs.
  task automatic predict();
    exp_t e;
    bit   old;
    ab_log.push_back(a & b);
    b_log.push_back(b);
    if (rst) begin
      rst_edge = k;
      e = '{c:0, ci:0, v:0, m:0, n8:0, s8:0, n3:0, s3:0};
      cnt8 = 0; cnt3 = 0; sat8 = 0; sat3 = 0;
    end else begin
      old  = (k - 5) > rst_edge;
      e.c  = (old ? ab_log[k-5] : 1'b0) | b;
      e.ci = old ? b_log[k-5] : 1'b0;
      e.v  = (k - rst_edge) >= 6;
      e.m  = e.v ? (e.c ^ e.ci) : 1'b0;
      if (clr_cnt) begin
        cnt8 = 0; cnt3 = 0; sat8 = 0; sat3 = 0;
      end else if (prev_m) begin
        if (!sat8) begin cnt8++; if (cnt8 == 255) sat8 = 1; end
        if (!sat3) begin cnt3++; if (cnt3 == 7)   sat3 = 1; end
      end
      e.n8 = 8'(cnt8); e.s8 = sat8;
      e.n3 = 3'(cnt3); e.s3 = sat3;
    end
    prev_m = e.m;
    sb.push_back(e);
    k++;
  endtask

  task automatic step(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      predict();
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("c",        32'(if8.c),        32'(e.c));
      check("c_ideal",  32'(if8.c_ideal),  32'(e.ci));
      check("c_valid",  32'(if8.c_valid),  32'(e.v));
      check("mismatch", 32'(if8.mismatch), 32'(e.m));
      check("cnt8",     32'(if8.mism_cnt), 32'(e.n8));
      check("sat8",     32'(if8.cnt_sat),  32'(e.s8));
      check("cnt3",     32'(if3.mism_cnt), 32'(e.n3));
      check("sat3",     32'(if3.cnt_sat),  32'(e.s3));
      check("c3",       32'(if3.c),        32'(e.c));
      check("mism3",    32'(if3.mismatch), 32'(e.m));
    end
  endtask

  initial begin
    rst = 1'b1; a = 1'b0; b = 1'b0; clr_cnt = 1'b0;
    #2;
    // 1: reset then fill with zeros
    step(1);
    rst = 1'b0;
    step(5);
    check("s1_not_valid_5", 32'(if8.c_valid), 32'd0);
    step(1);
    check("s1_valid_6", 32'(if8.c_valid), 32'd1);
    step(2);
    check("s1_cnt", 32'(if8.mism_cnt), 32'd0);
    // 2: b rises with a=0
    b = 1'b1;
    step(1);
    check("s2_c_fast", 32'(if8.c), 32'd1);
    check("s2_ci_slow", 32'(if8.c_ideal), 32'd0);
    step(9);
    check("s2_cnt", 32'(if8.mism_cnt), 32'd5);
    // 3: a=b=1 steady then b falls with a=1
    a = 1'b1;
    step(8);
    b = 1'b0;
    step(8);
    check("s3_cnt", 32'(if8.mism_cnt), 32'd5);
    // 4: a=0, b rises, then b falls with a=0
    a = 1'b0; b = 1'b1;
    step(8);
    b = 1'b0;
    step(1);
    check("s4_c_fall", 32'(if8.c), 32'd0);
    check("s4_ci_hold", 32'(if8.c_ideal), 32'd1);
    step(7);
    check("s4_cnt", 32'(if8.mism_cnt), 32'd15);
    check("s4_sat3", 32'(if3.cnt_sat), 32'd1);
    // 5: clear, toggle b every 6 cycles, then clear on a mismatch cycle
    clr_cnt = 1'b1;
    step(1);
    clr_cnt = 1'b0;
    check("s5_clr_cnt3", 32'(if3.mism_cnt), 32'd0);
    for (int t = 0; t < 6; t++) begin
      b = ~b;
      step(6);
    end
    check("s5_cnt3_sat", 32'(if3.mism_cnt), 32'd7);
    check("s5_sat3", 32'(if3.cnt_sat), 32'd1);
    check("s5_cnt8", 32'(if8.mism_cnt), 32'd30);
    b = 1'b1;
    step(2);
    check("s5_mism_live", 32'(if8.mismatch), 32'd1);
    clr_cnt = 1'b1;
    step(1);
    clr_cnt = 1'b0;
    check("s5_clr_wins_cnt", 32'(if3.mism_cnt), 32'd0);
    check("s5_clr_wins_sat", 32'(if3.cnt_sat), 32'd0);
    step(8);
    // 6: reset in the middle of a hazard
    b = 1'b0;
    step(8);
    b = 1'b1;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("s6_rst_valid", 32'(if8.c_valid), 32'd0);
    check("s6_rst_c", 32'(if8.c), 32'd0);
    check("s6_rst_cnt", 32'(if8.mism_cnt), 32'd0);
    step(5);
    check("s6_refill_5", 32'(if8.c_valid), 32'd0);
    step(1);
    check("s6_refill_6", 32'(if8.c_valid), 32'd1);
    step(6);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
